// File: rtl/sram_ctrl_pkg.sv
// Shared types, widths and address mapping for the SRAM memory controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW = 17;
  localparam int unsigned SRAM_DW = 64;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [SRAM_AW-1:0] line;
    logic               sel;
  } line_sel_t;

  // Byte address -> SRAM line and word half; offsets past 2^20 wrap silently.
  function automatic line_sel_t map_addr(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] offset;
    line_sel_t   r;
    offset = addr - base;
    r.line = offset[19:3];
    r.sel  = offset[2];
    return r;
  endfunction

endpackage

// File: rtl/sram_line_buffer.sv
// One-entry line buffer (tag, valid, 64-bit data) with hit compare.
module sram_line_buffer
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               fill_en,
  input  logic [SRAM_AW-1:0] fill_tag,
  input  logic [SRAM_DW-1:0] fill_data,
  input  logic [SRAM_AW-1:0] lookup_tag,
  output logic               hit_c,
  output logic [SRAM_DW-1:0] data
);

  logic               valid_q, valid_d;
  logic [SRAM_AW-1:0] tag_q, tag_d;
  logic [SRAM_DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_c = valid_q && (tag_q == lookup_tag);
  assign data  = data_q;

endmodule

// File: rtl/sram_mem_controller.sv
// 32-bit load/store to 64-bit SRAM bridge; stores are read-modify-write.
// Optional one-entry line buffer enabled by defining SRAM_CTRL_LINE_BUF_EN.
module sram_mem_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR        = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        addr,
  input  logic [WORD_W-1:0]  wdata,
  output logic [WORD_W-1:0]  rdata,
  output logic               ready,
  output logic               SRAM_WE_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

  localparam logic [31:0]      BASE_W  = 32'(BASE_ADDR);
  localparam int unsigned      CNT_W   = (SRAM_WAIT_CYCLES > 1) ? $clog2(SRAM_WAIT_CYCLES) : 1;
  // The request cycle counts toward the read phase, so RD lasts one cycle less than WR.
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(SRAM_WAIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(SRAM_WAIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_wr_q, is_wr_d;
  logic               sel_q, sel_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [SRAM_DW-1:0] line_q, line_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d;
  logic               we_n_q, we_n_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  line_sel_t          req_map;
  logic               hit_c;

  assign req_map = map_addr(addr, BASE_W);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    line_d      = line_q;
    rdata_d     = rdata_q;
    we_n_d      = we_n_q;
    sram_addr_d = sram_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if ((rd_en || wr_en) && !hit_c) begin
          is_wr_d     = wr_en;
          sel_d       = req_map.sel;
          wdata_d     = wdata;
          sram_addr_d = req_map.line;
          cnt_d       = '0;
          state_d     = ST_RD;
        end
      end
      ST_RD: begin
        if (cnt_q == LAST_RD) begin
          if (is_wr_q) begin
            line_d  = sel_q ? {wdata_q, SRAM_DQ[31:0]} : {SRAM_DQ[63:32], wdata_q};
            cnt_d   = '0;
            we_n_d  = 1'b0;
            state_d = ST_WR;
          end else begin
            line_d  = SRAM_DQ;
            state_d = ST_DONE;
          end
          rdata_d = sel_q ? line_d[63:32] : line_d[31:0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR: begin
        if (cnt_q == LAST_WR) begin
          we_n_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        sram_addr_d = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      sel_q       <= 1'b0;
      wdata_q     <= '0;
      line_q      <= '0;
      rdata_q     <= '0;
      we_n_q      <= 1'b1;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      line_q      <= line_d;
      rdata_q     <= rdata_d;
      we_n_q      <= we_n_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  // In IDLE ready tracks the request lines directly so the core freezes in the request cycle.
  always_comb begin
    if (state_q == ST_IDLE) ready = !(rd_en || wr_en) || hit_c;
    else                    ready = (state_q == ST_DONE);
  end

`ifdef SRAM_CTRL_LINE_BUF_EN
  logic               buf_hit_c;
  logic [SRAM_DW-1:0] buf_data;

  sram_line_buffer u_line_buf (
    .clk        (clk),
    .reset      (reset),
    .fill_en    ((state_q == ST_RD) && (cnt_q == LAST_RD)),
    .fill_tag   (sram_addr_q),
    .fill_data  (line_d),
    .lookup_tag (req_map.line),
    .hit_c      (buf_hit_c),
    .data       (buf_data)
  );

  assign hit_c = (state_q == ST_IDLE) && rd_en && !wr_en && buf_hit_c;
  assign rdata = hit_c ? (req_map.sel ? buf_data[63:32] : buf_data[31:0]) : rdata_q;
`else
  assign hit_c = 1'b0;
  assign rdata = rdata_q;
`endif

  assign SRAM_WE_N = we_n_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_DQ   = !we_n_q ? line_q : 'z;

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sits between the ARM core's MEM stage and the external 64-bit SRAM on the system board.
- Converts single-word 32-bit loads and stores into multi-cycle SRAM accesses.
- Holds ready low while an access is in progress; the core uses this to freeze its pipeline.
- A 32-bit store becomes a read-modify-write of the 64-bit SRAM line, because the SRAM has no byte or word enables.

Parameters:
- SRAM_WAIT_CYCLES, 5, core clock cycles per SRAM phase (read or write); must be >= 2 because the SRAM runs on a half-rate clock.
- BASE_ADDR, 1024, core byte address that maps to SRAM line 0.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- rd_en  in  1  load request from the MEM stage
- wr_en  in  1  store request from the MEM stage
- addr  in  32  core byte address
- wdata  in  32  store data
- rdata  out  32  load data; valid in the cycle ready=1 completes a load
- ready  out  1  0 = core must freeze
- SRAM_WE_N  out  1  SRAM write enable, active low
- SRAM_ADDR  out  17  SRAM line address
- SRAM_DQ  inout  64  SRAM data bus

Behaviour:
- Address mapping:
  - offset = addr - BASE_ADDR, computed modulo 2^32.
  - SRAM_ADDR = offset[19:3].
  - Word select = offset[2]: 0 selects DQ[31:0], 1 selects DQ[63:32].
  - offset[1:0] is ignored.
- Requests:
  - The request (rd_en, wr_en, addr, wdata) is latched on acceptance.
  - Inputs may change afterwards without effect until the operation completes.
  - rd_en and wr_en high together is treated as a write.
- FSM states: IDLE, RD, WR, DONE.
  - IDLE: ready = ~(rd_en | wr_en), combinational. On a request, latch it, clear the counter, go to RD.
  - RD: SRAM_WE_N=1, DQ released, SRAM_ADDR driven. Wait SRAM_WAIT_CYCLES cycles, then capture SRAM_DQ into the line register.
    - Load: go to DONE.
    - Store: merge wdata into the selected half of the line, clear the counter, go to WR.
  - WR: SRAM_WE_N=0 and SRAM_DQ = merged line for SRAM_WAIT_CYCLES cycles, then go to DONE.
  - DONE: ready=1 and rdata = selected word of the line register. Next state is IDLE unconditionally; a new request is accepted only from IDLE.
- Latency, counted from the request cycle to the ready=1 cycle:
  - Load: SRAM_WAIT_CYCLES+1 (6 at default).
  - Store: 2*SRAM_WAIT_CYCLES+1 (11 at default).
- SRAM_DQ is driven only in WR; in every other state it is high-Z.
- SRAM_ADDR is 0 in IDLE and holds the latched line address in RD, WR and DONE.
- Reset, including mid-operation, takes effect at the next clock edge:
  - State = IDLE, counter = 0, line register = 0, rdata = 0, SRAM_WE_N = 1, DQ released.
  - An aborted store may leave the SRAM line unmodified; it is never partially written in the same cycle as reset.
- Address wrap: an offset beyond 2^20 wraps silently through the bit slice; no error is flagged.

Optional Feature:
- Macro: SRAM_CTRL_LINE_BUF_EN.
- When defined, a one-entry line buffer is added: 17-bit tag, valid bit, and 64-bit data.
  - Load hit in IDLE (valid and tag == line address): ready stays 1 and rdata = the buffered word in the same cycle, combinationally; the FSM stays in IDLE.
  - Load miss: fills the buffer in RD.
  - Store, hit or miss: goes through the full RD/WR sequence (buffer contents are not used to skip the SRAM read); the buffer is loaded with the merged line and marked valid.
  - Reset clears the valid bit.
- When not defined, every load follows the full RD path with no buffer state.

Decomposition:
- Package sram_ctrl_pkg holds:
  - The FSM state enum.
  - Widths: SRAM_AW=17, SRAM_DW=64, WORD_W=32.
  - A function mapping a core byte address to the pair (line address, word select).
- One natural sub-module, sram_line_buffer: tag, valid and data registers plus hit compare. It is instantiated only under SRAM_CTRL_LINE_BUF_EN.

Test Plan:
1. Reset held 3 cycles, then idle → ready=1, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0, rdata=0.
2. Store addr=1024, wdata=0xDEADBEEF, then load addr=1024 → store: ready low 10 cycles, high on cycle 11; SRAM line 0 = 0x????????_DEADBEEF with the upper half unchanged. Load: rdata=0xDEADBEEF on cycle 6.
3. Stores 0x11111111 to 1032 and 0x22222222 to 1036, then load 1032 and 1036 → SRAM line 1 = 0x22222222_11111111; loads return 0x11111111 and 0x22222222.
4. Reset asserted in the 3rd WR cycle of a store → next cycle: IDLE, SRAM_WE_N=1, DQ=Z, ready=1; a following load completes normally.
5. rd_en=wr_en=1 at addr=1040 with wdata=0x5 → store timing (11 cycles); a later load of 1040 returns 0x5.
6. (SRAM_CTRL_LINE_BUF_EN) Load 1024 twice → first load ready at cycle 6; second has ready=1 in its request cycle with correct rdata. Then store to 1028 and load 1028 → the load hits and returns the stored value.
